// File: rtl/fme_sequencer.sv
// Block-level sequencer for fractional motion estimation: paces rows into interpolation, aligns enable_search, captures the result.
// Optional build macro FME_SEQ_BACK_TO_BACK_EN lets a new start be accepted in DONE.
module fme_sequencer #(
  parameter int DATAWIDTH   = 8,
  parameter int INT_LATENCY = 5,
  parameter int ROWS        = 8,
  parameter int SEARCH_TAIL = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  output logic                 ready,
  input  logic                 row_valid,
  output logic                 row_ack,
  output logic                 enable,
  output logic                 enable_search,
  input  logic [DATAWIDTH+8:0] best_sad,
  input  logic [5:0]           address_best_sad,
  output logic                 result_valid,
  output logic [DATAWIDTH+8:0] result_sad,
  output logic [5:0]           result_addr,
  output logic [7:0]           block_count
);

  localparam logic [7:0] LAST_ROW  = 8'(ROWS - 1);
  localparam logic [3:0] LAST_TAIL = 4'(SEARCH_TAIL - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN,
    DONE
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [INT_LATENCY-1:0] delay_line;
  logic [7:0]             row_cnt;
  logic [7:0]             row_cnt_next;
  logic [3:0]             tail_cnt;
  logic [3:0]             tail_cnt_next;
  logic                   capture;

  always_comb begin
    state_next    = state;
    row_cnt_next  = row_cnt;
    tail_cnt_next = tail_cnt;
    ready         = 1'b0;
    row_ack       = 1'b0;
    enable        = 1'b0;
    result_valid  = 1'b0;
    capture       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          state_next   = FILL;
          row_cnt_next = 8'd0;
        end
      end
      FILL: begin
        row_ack       = row_valid;
        enable        = row_valid;
        tail_cnt_next = 4'd0;
        if (row_valid) begin
          if (row_cnt == LAST_ROW) begin
            state_next = DRAIN;
          end else begin
            row_cnt_next = row_cnt + 8'd1;
          end
        end
      end
      DRAIN: begin
        // The tail only starts once every in-flight enable has reached search.
        if (delay_line == '0) begin
          if (tail_cnt == LAST_TAIL) begin
            capture    = 1'b1;
            state_next = DONE;
          end else begin
            tail_cnt_next = tail_cnt + 4'd1;
          end
        end
      end
      DONE: begin
        result_valid = 1'b1;
        state_next   = IDLE;
`ifdef FME_SEQ_BACK_TO_BACK_EN
        ready = 1'b1;
        if (start) begin
          state_next   = FILL;
          row_cnt_next = 8'd0;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      row_cnt     <= 8'd0;
      tail_cnt    <= 4'd0;
      result_sad  <= '0;
      result_addr <= 6'd0;
      block_count <= 8'd0;
    end else begin
      state    <= state_next;
      row_cnt  <= row_cnt_next;
      tail_cnt <= tail_cnt_next;
      if (capture) begin
        result_sad  <= best_sad;
        result_addr <= address_best_sad;
      end
      if (state == DONE) begin
        block_count <= block_count + 8'd1;
      end
    end
  end

  // Stall gaps in enable are carried through unchanged, so search sees the same row cadence.
  generate
    if (INT_LATENCY == 1) begin : g_delay_single
      always_ff @(posedge clock) begin
        if (reset) begin
          delay_line <= '0;
        end else begin
          delay_line <= enable;
        end
      end
    end else begin : g_delay_multi
      always_ff @(posedge clock) begin
        if (reset) begin
          delay_line <= '0;
        end else begin
          delay_line <= {delay_line[INT_LATENCY-2:0], enable};
        end
      end
    end
  endgenerate

  assign enable_search = delay_line[INT_LATENCY-1];

endmodule

// File: tb/tb_fme_sequencer.sv
// Testbench for fme_sequencer: directed blocks with a result scoreboard, plus a minimal-parameter instance.
// Honours FME_SEQ_BACK_TO_BACK_EN when the bench is built with it.
module tb_fme_sequencer;

  localparam int SW = 17;
`ifdef FME_SEQ_BACK_TO_BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          row_valid = 1'b0;
  logic [SW-1:0] best_sad = '0;
  logic [5:0]    address_best_sad = 6'd0;

  logic          ready, row_ack, enable, enable_search, result_valid;
  logic [SW-1:0] result_sad;
  logic [5:0]    result_addr;
  logic [7:0]    block_count;

  logic          s_ready, s_row_ack, s_enable, s_enable_search, s_result_valid;
  logic [SW-1:0] s_result_sad;
  logic [5:0]    s_result_addr;
  logic [7:0]    s_block_count;

  typedef struct {
    int          cycle;
    logic [SW-1:0] sad;
    logic [5:0]  addr;
    logic [7:0]  count;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] exp_count = 8'd0;
  logic [63:0] en_map, es_map, ack_map, rdy_map;
  logic [63:0] s_en_map, s_es_map, s_ack_map, s_rv_map;
  logic [SW-1:0] base;

  fme_sequencer u_dut (
    .clock(clock), .reset(reset), .start(start), .ready(ready),
    .row_valid(row_valid), .row_ack(row_ack), .enable(enable),
    .enable_search(enable_search), .best_sad(best_sad),
    .address_best_sad(address_best_sad), .result_valid(result_valid),
    .result_sad(result_sad), .result_addr(result_addr), .block_count(block_count)
  );

  fme_sequencer #(.DATAWIDTH(8), .INT_LATENCY(1), .ROWS(1), .SEARCH_TAIL(1)) u_small (
    .clock(clock), .reset(reset), .start(start), .ready(s_ready),
    .row_valid(row_valid), .row_ack(s_row_ack), .enable(s_enable),
    .enable_search(s_enable_search), .best_sad(best_sad),
    .address_best_sad(address_best_sad), .result_valid(s_result_valid),
    .result_sad(s_result_sad), .result_addr(s_result_addr), .block_count(s_block_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [63:0] bits(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Result due `rel` cycles after the start cycle; SAD/address are the values driven one cycle earlier.
  task automatic pushExpect(input int rel, input logic [SW-1:0] b);
    exp_t e;
    exp_count = exp_count + 8'd1;
    e.cycle   = cyc + 1 + rel;
    e.sad     = b + SW'(rel - 1);
    e.addr    = b[5:0] + 6'(rel - 1);
    e.count   = exp_count;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic [63:0] start_mask, input logic [63:0] rv_mask,
                               input int ncyc, input logic [SW-1:0] b, input int reset_at);
    en_map = '0; es_map = '0; ack_map = '0; rdy_map = '0;
    s_en_map = '0; s_es_map = '0; s_ack_map = '0; s_rv_map = '0;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clock);
      #1;
      reset            = (k == reset_at);
      start            = start_mask[k];
      row_valid        = rv_mask[k];
      best_sad         = b + SW'(k);
      address_best_sad = b[5:0] + 6'(k);
      @(negedge clock);
      en_map[k]    = enable;
      es_map[k]    = enable_search;
      ack_map[k]   = row_ack;
      rdy_map[k]   = ready;
      s_en_map[k]  = s_enable;
      s_es_map[k]  = s_enable_search;
      s_ack_map[k] = s_row_ack;
      s_rv_map[k]  = s_result_valid;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (result_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_result_valid: got result_valid=1 at cycle %0d, expected 0", cyc);
        end else begin
          e = sb.pop_front();
          checkOutput("result_cycle", 64'(cyc), 64'(e.cycle));
          checkOutput("result_sad", 64'(result_sad), 64'(e.sad));
          checkOutput("result_addr", 64'(result_addr), 64'(e.addr));
          @(negedge clock);
          checkOutput("block_count", 64'(block_count), 64'(e.count));
          checkOutput("result_sad_hold", 64'(result_sad), 64'(e.sad));
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    reset = 1'b1;
    row_valid = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("rst_ready", 64'(ready), 64'd1);
    checkOutput("rst_enable", 64'(enable), 64'd0);
    checkOutput("rst_row_ack", 64'(row_ack), 64'd0);
    checkOutput("rst_enable_search", 64'(enable_search), 64'd0);
    checkOutput("rst_result_valid", 64'(result_valid), 64'd0);
    checkOutput("rst_result_sad", 64'(result_sad), 64'd0);
    checkOutput("rst_result_addr", 64'(result_addr), 64'd0);
    checkOutput("rst_block_count", 64'(block_count), 64'd0);

    // Reset sampled at the end of cycle 10 (DRAIN) aborts the block with no result.
    applyStimulus(bits(0, 0), '1, 30, 17'd50, 10);
    checkOutput("abort_enable", en_map, bits(1, 8));
    checkOutput("abort_enable_search", es_map, bits(6, 10));
    checkOutput("abort_ready", rdy_map, bits(0, 0) | bits(11, 29));
    checkOutput("abort_result_sad", 64'(result_sad), 64'd0);
    checkOutput("abort_block_count", 64'(block_count), 64'd0);

    // Continuous rows: enable 1-8, enable_search 6-13, tail 14-16, result 17.
    base = 17'd1000;
    pushExpect(17, base);
    applyStimulus(bits(0, 0), '1, 20, base, -1);
    checkOutput("a_enable", en_map, bits(1, 8));
    checkOutput("a_enable_search", es_map, bits(6, 13));
    checkOutput("a_row_ack", ack_map, bits(1, 8));
    checkOutput("a_ready", rdy_map, bits(0, 0) | bits(18, 19) | (B2B ? bits(17, 17) : 64'd0));
    checkOutput("a_block_count", 64'(block_count), 64'd1);
    // Minimal instance: tail cycle 3 follows the single enable_search cycle 2, so the result lands in cycle 4.
    checkOutput("s_enable", s_en_map, bits(1, 1));
    checkOutput("s_row_ack", s_ack_map, bits(1, 1));
    checkOutput("s_enable_search", s_es_map, bits(2, 2));
    checkOutput("s_result_valid", s_rv_map, bits(4, 4));
    checkOutput("s_result_sad", 64'(s_result_sad), 64'(base + 17'd3));
    checkOutput("s_result_addr", 64'(s_result_addr), 64'(base[5:0] + 6'd3));
    checkOutput("s_block_count", 64'(s_block_count), 64'd1);
    checkOutput("s_ready", 64'(s_ready), 64'd1);

    // Gap in cycles 3-4 stretches the block by two cycles.
    base = 17'd2000;
    pushExpect(19, base);
    applyStimulus(bits(0, 0), ~bits(3, 4), 22, base, -1);
    checkOutput("b_enable", en_map, bits(1, 2) | bits(5, 10));
    checkOutput("b_enable_search", es_map, bits(6, 7) | bits(10, 15));
    checkOutput("b_ack_count", 64'($countones(ack_map)), 64'd8);
    checkOutput("b_ready", rdy_map, bits(0, 0) | bits(20, 21) | (B2B ? bits(19, 19) : 64'd0));

    // Extra starts in cycles 5 (FILL) and 17 (DONE).
    base = 17'd3000;
    pushExpect(17, base);
    if (B2B) pushExpect(34, base);
    applyStimulus(bits(0, 0) | bits(5, 5) | bits(17, 17), '1, 40, base, -1);
    checkOutput("c_enable", en_map, B2B ? (bits(1, 8) | bits(18, 25)) : bits(1, 8));
    checkOutput("c_enable_search", es_map, B2B ? (bits(6, 13) | bits(23, 30)) : bits(6, 13));
    checkOutput("c_ready", rdy_map,
                B2B ? (bits(0, 0) | bits(17, 17) | bits(34, 39)) : (bits(0, 0) | bits(18, 39)));
    checkOutput("c_block_count", 64'(block_count), 64'(exp_count));

    // 256 back-to-back blocks from a cleared counter: count climbs to 255 then wraps to 0.
    applyStimulus('0, '0, 2, '0, 0);
    exp_count = 8'd0;
    checkOutput("wrap_start_count", 64'(block_count), 64'd0);
    for (int i = 0; i < 256; i++) begin
      base = SW'(100 + i * 37);
      pushExpect(17, base);
      applyStimulus(bits(0, 0), '1, 18, base, -1);
      checkOutput("loop_enable", en_map & bits(0, 17), bits(1, 8));
      checkOutput("loop_enable_search", es_map & bits(0, 17), bits(6, 13));
    end
    applyStimulus('0, '0, 4, '0, -1);
    checkOutput("wrap_count", 64'(block_count), 64'd0);
    checkOutput("sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
